usart_ctrl: RTL and testbench
=============================

Name: usart_ctrl

Overview:
Command-driven UART transmit controller. A host writes 3-bit commands with an 8-bit operand. The block serialises bytes onto tx_pin as 8N1 frames, LSB first, at a programmable baud divisor. It sits between a simple CPU/bus write port and the board TX pin. It has a one-byte holding buffer behind the shift register.

Parameters:
CLOCK_HZ, 50000000, system clock frequency in Hz.
BAUD, 115200, reset baud rate.
DEFAULT_DIV, CLOCK_HZ/BAUD (434), reset value of the 16-bit divisor; clock cycles per bit.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  asynchronous, active-high reset.
write  input  1  command strobe, level; a command executes only on the 0->1 transition.
cmd_in  input  3  command code, sampled with write.
data_in  input  8  command operand, sampled with write.
tx_pin  output  1  serial output; idle high.
tx_busy  output  1  high while a frame is being shifted or the holding buffer is full.
tx_overrun  output  1  sticky; set when a transmit command is dropped.

Behaviour:
- Reset (async, while reset=1) sets: tx_pin=1, tx_busy=0, tx_overrun=0, divisor=DEFAULT_DIV, holding buffer empty, FSM=IDLE. Reset asserted mid-frame aborts the frame immediately.
- Command accept: a registered copy of write is kept. A command executes in cycle N when write=1 and the registered copy=0. Holding write high for many cycles executes the command exactly once.
- Commands:
  - 0 NOP.
  - 1 TX_RESET: abort any frame, tx_pin=1, empty the buffer, clear tx_overrun, FSM=IDLE. Divisor is kept.
  - 2 TRANSMIT data_in.
  - 3 load divisor[7:0]=data_in.
  - 4 load divisor[15:8]=data_in.
  - 5-7 are reserved and act as NOP.
- Divisor values below 2 are used as 2. A divisor change takes effect at the next bit boundary.
- TRANSMIT handling:
  - FSM IDLE: load the shift register.
  - FSM busy and buffer empty: store the byte in the buffer.
  - Buffer full: drop the byte and set tx_overrun.
- FSM states: IDLE, START, DATA (bit index 0..7), STOP.
  - IDLE -> START: registered, with tx_pin=0 from cycle N+1.
  - Each state/bit holds tx_pin for exactly divisor clocks. A bit counter counts divisor-1 down to 0.
  - DATA sends bit0 first, through bit7.
  - STOP drives tx_pin=1 for divisor clocks.
  - At the end of STOP: if the buffer is full, move its byte to the shift register, empty the buffer, and go directly to START with no idle gap. Otherwise go to IDLE.
- Frame length is 10*divisor clocks.
- tx_busy=1 from cycle N+1 until the last STOP clock completes with the buffer empty.
- tx_pin is driven from a register, so there are no glitches.
- Simultaneous events:
  - Reset dominates everything.
  - A TRANSMIT arriving on the same cycle a frame ends: the buffered byte, if any, is sent first. The new byte goes to the buffer, or is dropped if the buffer is still full.

Test Plan:
- Reset, then idle 100 ns -> tx_pin=1, tx_busy=0, tx_overrun=0.
- At 50 MHz, cmd 2, data 0xAA, write held 200 ns -> exactly one frame: 0,0,1,0,1,0,1,0,1,1. Each bit lasts 434 clks (8680 ns). tx_busy falls 4340 clks after the start; then tx_pin stays 1.
- cmd 3 data 0x10, cmd 4 data 0x00, then cmd 2 data 0x55 -> bits are 16 clks each, pattern 0,1,0,1,0,1,0,1,0,1.
- Three TRANSMITs (0x01, 0x02, 0x03) inside the first frame -> 0x01 and 0x02 are sent back-to-back with no idle gap; 0x03 is dropped; tx_overrun=1.
- Mid-frame cmd 1 -> tx_pin=1 the next cycle, tx_busy=0, tx_overrun cleared. A following cmd 2 starts a clean frame.
- Assert reset mid-frame -> tx_pin=1 asynchronously. After reset release the divisor is back to 434.

Source files
------------

// File: rtl/usart_ctrl_if.sv
// Host write port and serial status bundle for usart_ctrl.
`timescale 1ns/1ps
interface usart_ctrl_if;
    logic       write;
    logic [2:0] cmd_in;
    logic [7:0] data_in;
    logic       tx_pin;
    logic       tx_busy;
    logic       tx_overrun;

    modport master (
        output write, cmd_in, data_in,
        input  tx_pin, tx_busy, tx_overrun
    );

    modport slave (
        input  write, cmd_in, data_in,
        output tx_pin, tx_busy, tx_overrun
    );
endinterface

// File: rtl/usart_ctrl.sv
// Command-driven 8N1 UART transmitter with a one-byte holding buffer
// behind the shift register and a programmable 16-bit baud divisor.
`timescale 1ns/1ps
module usart_ctrl #(
    parameter int unsigned CLOCK_HZ    = 50000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned DEFAULT_DIV = CLOCK_HZ / BAUD
) (
    input logic        clk,
    input logic        reset,
    usart_ctrl_if.slave bus
);

    localparam logic [15:0] RST_DIV = 16'(DEFAULT_DIV);

    typedef enum logic [2:0] {
        CMD_NOP      = 3'd0,
        CMD_TX_RESET = 3'd1,
        CMD_TRANSMIT = 3'd2,
        CMD_DIV_LO   = 3'd3,
        CMD_DIV_HI   = 3'd4
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e      state_q, state_d;
    logic        write_q, write_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        ovr_q, ovr_d;
    logic [15:0] div_q, div_d;

    logic        fire;
    logic        is_tx;
    logic        bit_end;
    logic        stop_end;
    logic [15:0] eff_div;
    logic [15:0] reload;

    assign bus.tx_pin     = tx_q;
    assign bus.tx_busy    = busy_q;
    assign bus.tx_overrun = ovr_q;

    // Next-state logic: edge-detected command decode, bit timing and buffer handling.
    always_comb begin
        write_d     = bus.write;
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_d        = tx_q;
        ovr_d       = ovr_q;
        div_d       = div_q;

        fire     = bus.write & ~write_q;
        is_tx    = fire && (cmd_e'(bus.cmd_in) == CMD_TRANSMIT);
        eff_div  = (div_q < 16'd2) ? 16'd2 : div_q;
        reload   = eff_div - 16'd1;
        bit_end  = (cnt_q == '0);
        stop_end = (state_q == STOP) && bit_end;

        case (state_q)
            IDLE: begin
                if (is_tx) begin
                    shift_d = bus.data_in;
                    state_d = START;
                    tx_d    = 1'b0;
                    cnt_d   = reload;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                    cnt_d   = reload;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                    cnt_d = reload;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        state_d     = START;
                        tx_d        = 1'b0;
                        cnt_d       = reload;
                    end else if (is_tx) begin
                        shift_d = bus.data_in;
                        state_d = START;
                        tx_d    = 1'b0;
                        cnt_d   = reload;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A frame ending this cycle frees the buffer before the new byte is considered.
        if (is_tx && state_q != IDLE) begin
            if (stop_end && !hold_full_q) begin
                // byte already went straight to the shift register above
            end else if (!hold_full_q || stop_end) begin
                hold_d      = bus.data_in;
                hold_full_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end

        if (fire && cmd_e'(bus.cmd_in) == CMD_DIV_LO) div_d[7:0]  = bus.data_in;
        if (fire && cmd_e'(bus.cmd_in) == CMD_DIV_HI) div_d[15:8] = bus.data_in;

        if (fire && cmd_e'(bus.cmd_in) == CMD_TX_RESET) begin
            state_d     = IDLE;
            tx_d        = 1'b1;
            hold_full_d = 1'b0;
            ovr_d       = 1'b0;
            cnt_d       = '0;
            idx_d       = '0;
        end

        busy_d = (state_d != IDLE) || hold_full_d;
    end

    // State and registered outputs; reset aborts any frame immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            ovr_q       <= 1'b0;
            div_q       <= RST_DIV;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            ovr_q       <= ovr_d;
            div_q       <= div_d;
        end
    end

endmodule

// File: tb/tb_usart_ctrl.sv
// Directed bench for usart_ctrl: frame timing, divisor loads, buffering, overrun and resets.
`timescale 1ns/1ps
module tb_usart_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    usart_ctrl_if bus ();

    usart_ctrl #(
        .CLOCK_HZ (50000000),
        .BAUD     (115200)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 50 MHz clock.
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Overall time limit.
    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "time limit reached");
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Single-cycle command pulse; returns #1 after the edge that executes it.
    task automatic cmd(input logic [2:0] c, input logic [7:0] d);
        @(posedge clk); #1;
        bus.write   = 1'b1;
        bus.cmd_in  = c;
        bus.data_in = d;
        @(posedge clk); #1;
        bus.write   = 1'b0;
    endtask

    task automatic idle_cycles(input int unsigned n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Checks every bit of a frame at its first and last clock, then the state just after it.
    task automatic run_frame(input string tag, input logic [9:0] bits, input int unsigned div,
                             input bit start, input logic [7:0] data, input int unsigned hold,
                             input int unsigned c0, input logic exp_busy, input logic exp_pin);
        if (start) begin
            @(posedge clk); #1;
            bus.write   = 1'b1;
            bus.cmd_in  = 3'd2;
            bus.data_in = data;
            @(posedge clk); #1;
        end
        for (int unsigned c = c0; c < 10 * div; c++) begin
            if (start && c == hold - 1) bus.write = 1'b0;
            if (c % div == 0 || c % div == div - 1)
                chk($sformatf("%s_bit%0d_clk%0d", tag, c / div, c % div), bus.tx_pin, bits[c / div]);
            if (c % div == 0)
                chk($sformatf("%s_busy_bit%0d", tag, c / div), bus.tx_busy, 1'b1);
            @(posedge clk); #1;
        end
        chk($sformatf("%s_end_busy", tag), bus.tx_busy, exp_busy);
        chk($sformatf("%s_end_pin", tag), bus.tx_pin, exp_pin);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        bus.write    = 1'b0;
        bus.cmd_in   = 3'd0;
        bus.data_in  = 8'h00;

        // Reset state, then 100 ns idle.
        idle_cycles(3);
        chk("in_reset_pin", bus.tx_pin, 1'b1);
        chk("in_reset_busy", bus.tx_busy, 1'b0);
        reset = 1'b0;
        #100;
        chk("idle_pin", bus.tx_pin, 1'b1);
        chk("idle_busy", bus.tx_busy, 1'b0);
        chk("idle_ovr", bus.tx_overrun, 1'b0);

        // 0xAA at default divisor 434, write held 200 ns: one frame only.
        run_frame("aa434", 10'b1_1010_1010_0, 434, 1'b1, 8'hAA, 10, 0, 1'b0, 1'b1);
        idle_cycles(50);
        chk("aa434_after_pin", bus.tx_pin, 1'b1);
        chk("aa434_after_busy", bus.tx_busy, 1'b0);
        chk("aa434_after_ovr", bus.tx_overrun, 1'b0);

        // Divisor 16, then 0x55.
        cmd(3'd3, 8'h10);
        cmd(3'd4, 8'h00);
        run_frame("x55d16", 10'b1_0101_0101_0, 16, 1'b1, 8'h55, 1, 0, 1'b0, 1'b1);

        // Three transmits inside one frame: two back-to-back, third dropped.
        cmd(3'd2, 8'h01);
        chk("ovr_first_busy", bus.tx_busy, 1'b1);
        chk("ovr_first_pin", bus.tx_pin, 1'b0);
        cmd(3'd2, 8'h02);
        chk("ovr_after2", bus.tx_overrun, 1'b0);
        cmd(3'd2, 8'h03);
        chk("ovr_after3", bus.tx_overrun, 1'b1);
        run_frame("b2b_01", 10'b1_0000_0001_0, 16, 1'b0, 8'h00, 1, 4, 1'b1, 1'b0);
        run_frame("b2b_02", 10'b1_0000_0010_0, 16, 1'b0, 8'h00, 1, 0, 1'b0, 1'b1);
        chk("ovr_sticky", bus.tx_overrun, 1'b1);

        // Mid-frame TX_RESET.
        cmd(3'd2, 8'h55);
        idle_cycles(40);
        chk("txrst_pre_pin", bus.tx_pin, 1'b0);
        cmd(3'd1, 8'h00);
        chk("txrst_pin", bus.tx_pin, 1'b1);
        chk("txrst_busy", bus.tx_busy, 1'b0);
        chk("txrst_ovr", bus.tx_overrun, 1'b0);
        idle_cycles(20);
        chk("txrst_hold_pin", bus.tx_pin, 1'b1);
        chk("txrst_hold_busy", bus.tx_busy, 1'b0);
        run_frame("clean_aa", 10'b1_1010_1010_0, 16, 1'b1, 8'hAA, 1, 0, 1'b0, 1'b1);

        // Divisor of 1 behaves as 2.
        cmd(3'd3, 8'h01);
        run_frame("div1_c3", 10'b1_1100_0011_0, 2, 1'b1, 8'hC3, 1, 0, 1'b0, 1'b1);
        cmd(3'd3, 8'h10);

        // Reset mid-frame with overrun set; divisor returns to 434.
        cmd(3'd2, 8'h01);
        cmd(3'd2, 8'h02);
        cmd(3'd2, 8'h03);
        chk("rst_pre_ovr", bus.tx_overrun, 1'b1);
        idle_cycles(32);
        chk("rst_pre_pin", bus.tx_pin, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_async_pin", bus.tx_pin, 1'b1);
        chk("rst_async_busy", bus.tx_busy, 1'b0);
        chk("rst_async_ovr", bus.tx_overrun, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle_cycles(2);
        chk("rst_idle_pin", bus.tx_pin, 1'b1);
        run_frame("x0f434", 10'b1_0000_1111_0, 434, 1'b1, 8'h0F, 1, 0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
